lfsr_check: RTL and testbench

Receive-side checker for the 32-bit-per-cycle LFSR pattern produced by the TX pattern generator. It self-synchronises to the incoming word stream, then flags and counts words that deviate from the predicted sequence. It sits on the GT_PHY RX user-data path behind the 32-bit RX datapath, for link BER/loopback testing. It declares loss of sync after sustained mismatches.

---
 rtl/lfsr_check.sv | 177 +++++++++++++++++
 tb/tb_lfsr_check.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_check.sv
// Receive-side checker for the 32-bit-per-cycle LFSR test pattern: hunts, verifies, locks, counts errors.
// Optional per-bit error counter is built only when LFSR_CHK_BITCNT_EN is defined.
module lfsr_check #(
  parameter int unsigned P_LOCK_CNT   = 4,
  parameter int unsigned P_UNLOCK_CNT = 8,
  parameter int unsigned P_CNT_W      = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [31:0]        i_data,
  input  logic               i_clr_cnt,
  output logic               o_lock,
  output logic               o_err,
  output logic [P_CNT_W-1:0] o_err_cnt,
  output logic [P_CNT_W-1:0] o_bit_err_cnt
);

  localparam logic [7:0] LockCnt   = 8'(P_LOCK_CNT);
  localparam logic [7:0] UnlockCnt = 8'(P_UNLOCK_CNT);

  typedef enum logic [1:0] {
    StHunt,
    StVerify,
    StLock
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        seed_q, seed_d;
  logic [7:0]         match_cnt_q, match_cnt_d, match_inc;
  logic [7:0]         miss_cnt_q, miss_cnt_d, miss_inc;
  logic               err_q, err_d;
  logic [P_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [47:0]        pred_ext;
  logic [31:0]        pred;
  logic               match;
  logic               seed_zero;

  // Unroll the recurrence from the oldest predicted bit (31) down to the newest (0).
  always_comb begin
    pred_ext = {seed_q, 32'h0};
    for (int k = 31; k >= 0; k--) begin
      pred_ext[k] = pred_ext[k+16] ^ pred_ext[k+15] ^ pred_ext[k+14] ^ pred_ext[k+2];
    end
  end

  assign pred      = pred_ext[31:0];
  assign match     = (i_data == pred);
  assign seed_zero = (i_data[15:0] == 16'h0);
  assign match_inc = match_cnt_q + 8'd1;
  assign miss_inc  = miss_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_d       = 1'b0;
    if (i_valid) begin
      case (state_q)
        StHunt: begin
          if (!seed_zero) begin
            seed_d      = i_data[15:0];
            match_cnt_d = 8'd0;
            state_d     = StVerify;
          end
        end
        StVerify: begin
          if (match) begin
            seed_d      = i_data[15:0];
            match_cnt_d = match_inc;
            if (match_inc == LockCnt) begin
              state_d    = StLock;
              miss_cnt_d = 8'd0;
            end
          end else if (!seed_zero) begin
            seed_d      = i_data[15:0];
            match_cnt_d = 8'd0;
          end else begin
            match_cnt_d = 8'd0;
            state_d     = StHunt;
          end
        end
        StLock: begin
          // Follow the prediction so one corrupted word cannot derail the following ones.
          seed_d = pred[15:0];
          if (match) begin
            miss_cnt_d = 8'd0;
          end else begin
            err_d      = 1'b1;
            miss_cnt_d = miss_inc;
            if (miss_inc == UnlockCnt) begin
              state_d = StHunt;
            end
          end
        end
        default: begin
          state_d = StHunt;
        end
      endcase
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (i_clr_cnt) begin
      err_cnt_d = '0;
    end else if (err_d && (err_cnt_q != {P_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + P_CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= StHunt;
      seed_q      <= 16'h0;
      match_cnt_q <= 8'd0;
      miss_cnt_q  <= 8'd0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_lock    = (state_q == StLock);
  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;

`ifdef LFSR_CHK_BITCNT_EN
  // Sum is wide enough for a full 32-bit popcount even with narrow counters.
  localparam int unsigned SumW = ((P_CNT_W > 6) ? P_CNT_W : 6) + 1;

  logic [31:0]        diff;
  logic [5:0]         bit_errs;
  logic [SumW-1:0]    bit_sum;
  logic [P_CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  assign diff = i_data ^ pred;

  always_comb begin
    bit_errs = 6'd0;
    for (int k = 0; k < 32; k++) begin
      bit_errs = bit_errs + 6'(diff[k]);
    end
  end

  assign bit_sum = SumW'(bit_cnt_q) + SumW'(bit_errs);

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (i_clr_cnt) begin
      bit_cnt_d = '0;
    end else if (err_d) begin
      bit_cnt_d = (bit_sum > SumW'({P_CNT_W{1'b1}})) ? {P_CNT_W{1'b1}} : P_CNT_W'(bit_sum);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      bit_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign o_bit_err_cnt = bit_cnt_q;
`else
  assign o_bit_err_cnt = '0;
`endif

endmodule

// File: tb/tb_lfsr_check.sv
// Bench for lfsr_check: segment table plus hand sequences, per-cycle scoreboard from an intent model.
module tb_lfsr_check;

  localparam int LockN   = 4;
  localparam int UnlockN = 8;
`ifdef LFSR_CHK_BITCNT_EN
  localparam bit BitsOn = 1'b1;
`else
  localparam bit BitsOn = 1'b0;
`endif

  typedef enum int {KClean, KFlip, KRand, KZero} kind_e;

  typedef struct packed {
    logic        lock;
    logic        err;
    logic [15:0] cnt;
    logic [15:0] bits;
    logic [3:0]  cnt4;
    logic [3:0]  bits4;
  } exp_t;

  typedef struct {
    int    n;
    kind_e kind;
    bit    toggle;
    bit    exp_lock;
    int    exp_cnt;
    int    exp_bits;  // -1: not checked
  } seg_t;

  logic        clk = 1'b0;
  logic        rst_n, valid, clr;
  logic [31:0] data;
  logic        lock, err, lock4, err4;
  logic [15:0] err_cnt, bit_cnt;
  logic [3:0]  err_cnt4, bit_cnt4;

  always #5 clk = ~clk;

  lfsr_check dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_valid      (valid),
    .i_data       (data),
    .i_clr_cnt    (clr),
    .o_lock       (lock),
    .o_err        (err),
    .o_err_cnt    (err_cnt),
    .o_bit_err_cnt(bit_cnt)
  );

  lfsr_check #(.P_CNT_W(4)) dut4 (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_valid      (valid),
    .i_data       (data),
    .i_clr_cnt    (clr),
    .o_lock       (lock4),
    .o_err        (err4),
    .o_err_cnt    (err_cnt4),
    .o_bit_err_cnt(bit_cnt4)
  );

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];

  // Intent model state
  logic [15:0] gen_sr = 16'hA076;
  bit          m_locked;
  int          m_clean_run, m_bad_run, m_cnt, m_bits, m_cnt4, m_bits4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bit-serial TX generator: each new bit is the XOR of the bits 16, 15, 14 and 2 places back.
  task automatic gen_next(output logic [31:0] w);
    logic nb;
    w = 32'h0;
    for (int n = 0; n < 32; n++) begin
      nb     = gen_sr[15] ^ gen_sr[14] ^ gen_sr[13] ^ gen_sr[1];
      gen_sr = {gen_sr[14:0], nb};
      w      = {w[30:0], nb};
    end
  endtask

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic cycle(input bit v, input kind_e kind, input bit c, input bit r);
    logic [31:0] g, w;
    exp_t        e;
    int          pc;
    bit          e_err;
    g     = 32'h0;
    w     = $urandom;
    e_err = 1'b0;
    if (v && kind != KZero) gen_next(g);
    if (v) begin
      case (kind)
        KClean: w = g;
        KFlip:  w = g ^ 32'h1;
        KRand:  while (w == g) w = $urandom;
        default: w = 32'h0;
      endcase
    end
    if (!r) begin
      m_locked = 0; m_clean_run = 0; m_bad_run = 0;
      m_cnt = 0; m_bits = 0; m_cnt4 = 0; m_bits4 = 0;
    end else if (v) begin
      if (!m_locked) begin
        if (kind == KClean) begin
          m_clean_run++;
          if (m_clean_run == LockN + 1) begin
            m_locked  = 1;
            m_bad_run = 0;
          end
        end else begin
          m_clean_run = 0;
        end
      end else if (kind == KClean) begin
        m_bad_run = 0;
      end else begin
        e_err   = 1'b1;
        pc      = BitsOn ? $countones(w ^ g) : 0;
        m_cnt   = sat(m_cnt + 1, 65535);
        m_cnt4  = sat(m_cnt4 + 1, 15);
        m_bits  = sat(m_bits + pc, 65535);
        m_bits4 = sat(m_bits4 + pc, 15);
        m_bad_run++;
        if (m_bad_run == UnlockN) begin
          m_locked    = 0;
          m_clean_run = 0;
        end
      end
    end
    if (r && c) begin
      m_cnt = 0; m_bits = 0; m_cnt4 = 0; m_bits4 = 0;
    end
    e.lock  = m_locked;
    e.err   = e_err;
    e.cnt   = 16'(m_cnt);
    e.bits  = 16'(m_bits);
    e.cnt4  = 4'(m_cnt4);
    e.bits4 = 4'(m_bits4);
    rst_n = r;
    valid = v;
    data  = w;
    clr   = c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("o_lock", 32'(lock), 32'(e.lock));
      check("o_err", 32'(err), 32'(e.err));
      check("o_err_cnt", 32'(err_cnt), 32'(e.cnt));
      check("o_bit_err_cnt", 32'(bit_cnt), 32'(e.bits));
      check("w4_o_lock", 32'(lock4), 32'(e.lock));
      check("w4_o_err", 32'(err4), 32'(e.err));
      check("w4_o_err_cnt", 32'(err_cnt4), 32'(e.cnt4));
      check("w4_o_bit_err_cnt", 32'(bit_cnt4), 32'(e.bits4));
    end
  endtask

  seg_t segs[7];

  initial begin
    segs[0] = '{n: 50,   kind: KZero,  toggle: 0, exp_lock: 0, exp_cnt: 0, exp_bits: 0};
    segs[1] = '{n: 1000, kind: KClean, toggle: 0, exp_lock: 1, exp_cnt: 0, exp_bits: 0};
    segs[2] = '{n: 1,    kind: KFlip,  toggle: 0, exp_lock: 1, exp_cnt: 1,
                exp_bits: BitsOn ? 1 : 0};
    segs[3] = '{n: 20,   kind: KClean, toggle: 0, exp_lock: 1, exp_cnt: 1, exp_bits: -1};
    segs[4] = '{n: 8,    kind: KRand,  toggle: 0, exp_lock: 0, exp_cnt: 9, exp_bits: -1};
    segs[5] = '{n: 5,    kind: KClean, toggle: 0, exp_lock: 1, exp_cnt: 9, exp_bits: -1};
    segs[6] = '{n: 40,   kind: KClean, toggle: 1, exp_lock: 1, exp_cnt: 9, exp_bits: -1};

    rst_n = 1'b0; valid = 1'b0; data = 32'h0; clr = 1'b0;
    cycle(0, KClean, 0, 0);
    cycle(0, KClean, 0, 0);

    foreach (segs[i]) begin
      for (int j = 0; j < segs[i].n; j++) begin
        cycle(segs[i].toggle ? (j % 2 == 0) : 1'b1, segs[i].kind, 0, 1);
      end
      check($sformatf("seg%0d_lock", i), 32'(lock), 32'(segs[i].exp_lock));
      check($sformatf("seg%0d_err_cnt", i), 32'(err_cnt), 32'(segs[i].exp_cnt));
      if (segs[i].exp_bits >= 0) begin
        check($sformatf("seg%0d_bit_cnt", i), 32'(bit_cnt), 32'(segs[i].exp_bits));
      end
    end

    // Clear in the same cycle as an error: clear wins, the pulse still fires.
    cycle(1, KFlip, 1, 1);
    check("clr_vs_err_cnt", 32'(err_cnt), 32'd0);
    check("clr_vs_err_pulse", 32'(err), 32'd1);
    check("clr_vs_err_lock", 32'(lock), 32'd1);
    cycle(1, KClean, 0, 1);

    // Twenty isolated errors: 16-bit counter reaches 20, 4-bit counter pins at 15.
    for (int j = 0; j < 20; j++) begin
      cycle(1, KFlip, 0, 1);
      cycle(1, KClean, 0, 1);
    end
    check("sat_err_cnt16", 32'(err_cnt), 32'd20);
    check("sat_err_cnt4", 32'(err_cnt4), 32'hF);
    check("sat_lock4", 32'(lock4), 32'd1);
    check("sat_bit_cnt16", 32'(bit_cnt), BitsOn ? 32'd20 : 32'd0);

    // Reset applied while locked drops lock on the next edge; clean stream then relocks.
    cycle(1, KClean, 0, 0);
    check("midlock_rst_lock", 32'(lock), 32'd0);
    check("midlock_rst_cnt", 32'(err_cnt), 32'd0);
    for (int j = 0; j < LockN; j++) cycle(1, KClean, 0, 1);
    check("relock_not_early", 32'(lock), 32'd0);
    cycle(1, KClean, 0, 1);
    check("relock_lock", 32'(lock), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
